// File: rtl/free_list_ctrl_pkg.sv
//------------------------------------------------------------------------------
// free_list_ctrl_pkg
// Shared rename-stage constants and tag/pointer types.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package free_list_ctrl_pkg;

    localparam int PHYS_REGS  = 64;
    localparam int ARCH_REGS  = 32;
    localparam int FREE_DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int TAG_W      = $clog2(PHYS_REGS);
    localparam int IDX_W      = $clog2(FREE_DEPTH);
    localparam int PTR_W      = IDX_W + 1;

    typedef logic [TAG_W-1:0]           phys_tag_t;
    typedef logic [$clog2(FREE_DEPTH):0] fl_ptr_t;

endpackage

`default_nettype wire

// File: rtl/free_list_ctrl.sv
//------------------------------------------------------------------------------
// free_list_ctrl
// Physical-tag free list: speculative allocate, commit reclaim, flush rewind.
// Optional protocol checking enabled by defining FREELIST_CHECK_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module free_list_ctrl
    import free_list_ctrl_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             alloc_req,
    output logic             alloc_valid,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             commit_valid,
    input  logic [TAG_W-1:0] commit_free_tag,
    input  logic             flush,
    output logic [TAG_W-1:0] free_count,
    output logic             rename_halt,
    output logic             proto_err
);

    phys_tag_t mem_q [FREE_DEPTH];
    phys_tag_t mem_d [FREE_DEPTH];
    fl_ptr_t   spec_head_q, spec_head_d;
    fl_ptr_t   commit_head_q, commit_head_d;
    fl_ptr_t   tail_q, tail_d;

    fl_ptr_t   w_free_cnt;
    logic      w_full;
    logic      w_empty;
    logic      w_alloc_fire;
    logic      w_commit_fire;

    assign w_free_cnt    = tail_q - spec_head_q;
    assign w_full        = (w_free_cnt == fl_ptr_t'(FREE_DEPTH));
    assign w_empty       = (w_free_cnt == '0);
    assign w_alloc_fire  = alloc_req & ~w_empty & ~flush;
    assign w_commit_fire = commit_valid & ~w_full;

    assign alloc_valid = ~w_empty;
    assign rename_halt = w_empty;
    assign free_count  = TAG_W'(w_free_cnt);
    assign alloc_tag   = mem_q[spec_head_q[IDX_W-1:0]];

    always_comb begin
        mem_d         = mem_q;
        spec_head_d   = spec_head_q;
        commit_head_d = commit_head_q;
        tail_d        = tail_q;
        if (w_commit_fire) begin
            mem_d[tail_q[IDX_W-1:0]] = commit_free_tag;
            tail_d        = tail_q + fl_ptr_t'(1);
            commit_head_d = commit_head_q + fl_ptr_t'(1);
        end
        // Flush rewinds to the committed point including this cycle's commit.
        if (flush) begin
            spec_head_d = commit_head_d;
        end else if (w_alloc_fire) begin
            spec_head_d = spec_head_q + fl_ptr_t'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < FREE_DEPTH; i++) begin
                mem_q[i] <= phys_tag_t'(ARCH_REGS + i);
            end
            spec_head_q   <= '0;
            commit_head_q <= '0;
            tail_q        <= fl_ptr_t'(FREE_DEPTH);
        end else begin
            mem_q         <= mem_d;
            spec_head_q   <= spec_head_d;
            commit_head_q <= commit_head_d;
            tail_q        <= tail_d;
        end
    end

`ifdef FREELIST_CHECK_EN
    logic        proto_err_q, proto_err_d;
    logic [31:0] cycle_q, cycle_d;
    logic        w_err_ovf;
    logic        w_err_udf;
    logic        w_err_zero;
    logic        w_err_overrun;

    assign w_err_ovf     = commit_valid & w_full;
    assign w_err_udf     = alloc_req & w_empty;
    assign w_err_zero    = commit_valid & (commit_free_tag == '0);
    assign w_err_overrun = w_commit_fire & (commit_head_q == spec_head_q);

    always_comb begin
        cycle_d     = cycle_q + 32'd1;
        proto_err_d = proto_err_q | w_err_ovf | w_err_udf | w_err_zero | w_err_overrun;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            proto_err_q <= 1'b0;
            cycle_q     <= '0;
        end else begin
            proto_err_q <= proto_err_d;
            cycle_q     <= cycle_d;
            if (w_err_ovf)     $display("free_list_ctrl: cycle %0d protocol error: commit overflow", cycle_q);
            if (w_err_udf)     $display("free_list_ctrl: cycle %0d protocol error: alloc while empty", cycle_q);
            if (w_err_zero)    $display("free_list_ctrl: cycle %0d protocol error: reclaim of tag 0", cycle_q);
            if (w_err_overrun) $display("free_list_ctrl: cycle %0d protocol error: commit_head passed spec_head", cycle_q);
        end
    end

    assign proto_err = proto_err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/free_list_ctrl.md
# free_list_ctrl

Physical-register free-list controller for the rename stage: hands one free physical tag per cycle to Rename for a destination remap. It reclaims each superseded mapping when the owning instruction commits, and on a pipeline flush rewinds the speculative allocation point to the committed point. It sits between Rename (allocation), the ROB/RRAT commit path (reclaim) and the Request_Alt_PC flush.

## Interface
- PHYS_REGS, 64: physical register count.
- ARCH_REGS, 32: architectural register count; the free list depth is PHYS_REGS-ARCH_REGS.
- TAG_W, 6: physical tag width, log2(PHYS_REGS).
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  **synchronous, active-low** reset.
- alloc_req  in  1  Rename consumes alloc_tag this cycle; honored only while alloc_valid=1.
- alloc_valid  out  1  free list non-empty.
- alloc_tag  out  TAG_W  tag at the speculative head.
- commit_valid  in  1  one committing instruction that allocated a tag.
- commit_free_tag  in  TAG_W  previous mapping of that instruction's destination, returned to the list.
- flush  in  1  mispredict/exception recovery.
- free_count  out  TAG_W  free tags visible to allocation, range 0..32.
- rename_halt  out  1  equals !alloc_valid; stalls the rename queue.
- proto_err  out  1  sticky protocol-error flag (see Configuration).

## Operation
- Storage: circular array of 32 tags plus three pointers, each log2(depth)+1 = 6 bits with a wrap bit.
  - spec_head: next tag to allocate.
  - commit_head: allocation point as of the last commit.
  - tail: next reclaim slot.
- Reset (RESET=0 at an edge):
  - entry i is loaded with tag 32+i, so tags 0..31 start as the identity architectural mapping.
  - spec_head=0, commit_head=0, tail=32 (wrap bit set, index 0), proto_err=0.
- Outputs during and after reset: alloc_valid=1, alloc_tag=32, free_count=32, rename_halt=0.
- Allocate: alloc_req & alloc_valid advances spec_head by 1. alloc_req while empty is ignored.
- Commit: commit_valid writes commit_free_tag at tail, then advances both tail and commit_head by 1.
- Flush: spec_head <= commit_head, or commit_head+1 if commit_valid is also asserted that cycle. Any same-cycle allocate is dropped.
- free_count = tail - spec_head, modulo 64.
- alloc_valid = (free_count != 0).
- No bypass: a tag reclaimed in cycle N is allocatable from cycle N+1.
- Tag 0 is never allocated or reclaimed.
- Priority within a cycle: reset > flush > commit/alloc. Commit and alloc in the same cycle both take effect.
- All pointer arithmetic wraps at 64 (index 0..31, wrap bit toggles).

## Timing
- alloc_valid, alloc_tag, free_count and rename_halt are combinational from flops only, with no input-to-output path.
- Allocation latency: the tag is available in the same cycle it is requested; the head advances at the next edge.
- Flush takes effect in one cycle: alloc_tag reflects the restored head on the cycle after flush.
- Reset in mid-operation discards all speculative and committed pointer state; the list is fully reinitialized in one cycle.
- Full (free_count=32) with commit_valid=1 is an overflow; the write is suppressed.
- Empty with alloc_req=1 is an underflow; the request is ignored.

## Configuration
- FREELIST_CHECK_EN defined:
  - proto_err sets, and stays set until reset, on any of:
    - overflow commit;
    - alloc_req while empty;
    - commit_free_tag == 0;
    - commit_head advancing past spec_head.
  - A $display with the cycle and cause is printed.
- FREELIST_CHECK_EN undefined:
  - proto_err is tied 0 and no checking logic is built.
  - Overflow and underflow suppression are still present.

## Structure
- Shared package holds:
  - constants PHYS_REGS, ARCH_REGS, FREE_DEPTH and TAG_W;
  - typedef phys_tag_t (logic [TAG_W-1:0]);
  - typedef fl_ptr_t (logic [$clog2(FREE_DEPTH):0]).
- FRAT, RRAT, Rename and PHYS_REG all use these.
- Single module; no sub-module. The array and the three pointers are small enough to keep inline.

## Test plan
- Reset, then alloc_req held for 33 cycles: tags 32..63 are returned in order; after 32 grants alloc_valid=0, rename_halt=1, free_count=0.
- Drain the list, then commit_valid with tag 5: the next cycle alloc_valid=1, alloc_tag=5, free_count=1.
- Allocate 4 tags (32..35), commit 1 (free tag 7), then flush: free_count=32-1+1=32, and alloc_tag=33 (restored to commit_head=1).
- Flush, commit_valid and alloc_req in the same cycle from spec_head=3, commit_head=1: spec_head becomes 2 and the allocate is dropped.
- Commit with the list full (free_count=32): tail is unchanged; with FREELIST_CHECK_EN, proto_err=1 and stays 1 until RESET=0.
- Pulse RESET=0 after 10 allocations: the next cycle alloc_tag=32, free_count=32, proto_err=0.
